// File: rtl/dds_frame_streamer.sv
// Serial front-end for AD995x DDS chips: holds the DDS in reset, sends the init bytes over one lane, then streams per-channel frames over LANES lanes.
// Optional build macro DDS_UPDATE_PER_CH_EN: pulse IO_UPDATE after every channel command instead of once per frame.
module dds_frame_streamer #(
    parameter int NUM_CH      = 2,
    parameter int LANES       = 4,
    parameter int INIT_BYTES  = 12,
    parameter int CSR_CH_BASE = 6,
    parameter int RESET_HOLD  = 1023,
    parameter int GAP         = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8*INIT_BYTES-1:0] init_word,
    input  logic [NUM_CH-1:0]       ch_mask,
    input  logic                    frame_valid,
    output logic                    frame_ready,
    input  logic [32*NUM_CH-1:0]    frame_freq,
    input  logic [10*NUM_CH-1:0]    frame_amp,
    output logic                    busy,
    output logic                    dds_reset,
    output logic                    dds_cs,
    output logic                    dds_sclk,
    output logic                    dds_io_update,
    output logic [3:0]              dds_sdio,
    output logic [2:0]              o_dbg_state
);

    localparam int CMD_W    = 88;
    localparam int INIT_W   = 8 * INIT_BYTES;
    localparam int SH_W     = (INIT_W > CMD_W) ? INIT_W : CMD_W;
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LANE_EFF = (LANES == 4) ? 4 : 1;
    localparam int CNT_MAX0 = (RESET_HOLD > INIT_W) ? RESET_HOLD : INIT_W;
    localparam int CNT_MAX1 = (CNT_MAX0 > CMD_W) ? CNT_MAX0 : CMD_W;
    localparam int CNT_MAX  = (CNT_MAX1 > GAP + 2) ? CNT_MAX1 : GAP + 2;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_HOLD - 1);
    localparam logic [CNT_W-1:0] INIT_LAST    = CNT_W'(INIT_W - 1);
    localparam logic [CNT_W-1:0] CMD_LAST     = CNT_W'(CMD_W / LANE_EFF - 1);
    localparam logic [CNT_W-1:0] INITUPD_LAST = CNT_W'(GAP + 1);
    localparam logic [CNT_W-1:0] UPD_LAST     = CNT_W'(1);

    localparam logic [2:0] S_DDSRST  = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_INITUPD = 3'd2;
    localparam logic [2:0] S_IDLE    = 3'd3;
    localparam logic [2:0] S_SHIFT   = 3'd4;
    localparam logic [2:0] S_UPDATE  = 3'd5;

    logic [2:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_phase;
    logic [SH_W-1:0]        r_shreg;
    logic [CH_W-1:0]        r_ch;
    logic [NUM_CH-1:0]      r_mask;
    logic [32*NUM_CH-1:0]   r_freq;
    logic [10*NUM_CH-1:0]   r_amp;

    logic                   w_cs_low;
    logic [CH_W:0]          w_first;
    logic [CH_W:0]          w_next;
    logic [CMD_W-1:0]       w_first_cmd;
    logic [CMD_W-1:0]       w_next_cmd;

    // Lowest enabled channel, optionally restricted to channels above 'floor'; MSB is the found flag.
    function automatic logic [CH_W:0] find_ch(input logic [NUM_CH-1:0] mask,
                                              input logic use_floor,
                                              input logic [CH_W-1:0] floor);
        logic [CH_W:0] res;
        res = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (!use_floor || i > int'(floor))) begin
                res = {1'b1, CH_W'(i)};
            end
        end
        return res;
    endfunction

    function automatic logic [CMD_W-1:0] build_cmd(input logic [CH_W-1:0] ch,
                                                   input logic [31:0] ftw,
                                                   input logic [9:0] amp);
        logic [7:0] csr;
        csr = 8'(1) << (CSR_CH_BASE + int'(ch));
        if (LANES == 4) begin
            csr[2:1] = 2'b11;
        end
        return {8'h00, csr, 8'h04, ftw, 8'h06, 8'h00, 6'b000100, amp};
    endfunction

    function automatic logic [SH_W-1:0] align_cmd(input logic [CMD_W-1:0] cmd);
        return SH_W'(cmd) << (SH_W - CMD_W);
    endfunction

    assign w_first     = find_ch(ch_mask, 1'b0, '0);
    assign w_next      = find_ch(r_mask, 1'b1, r_ch);
    assign w_first_cmd = build_cmd(w_first[CH_W-1:0],
                                   frame_freq[32*w_first[CH_W-1:0] +: 32],
                                   frame_amp[10*w_first[CH_W-1:0] +: 10]);
    assign w_next_cmd  = build_cmd(w_next[CH_W-1:0],
                                   r_freq[32*w_next[CH_W-1:0] +: 32],
                                   r_amp[10*w_next[CH_W-1:0] +: 10]);

    assign w_cs_low      = (r_state == S_INIT) || (r_state == S_SHIFT);
    assign dds_cs        = ~w_cs_low;
    assign dds_sclk      = r_phase & w_cs_low;
    assign dds_reset     = (r_state == S_DDSRST);
    assign dds_io_update = ((r_state == S_INITUPD) && (r_cnt < CNT_W'(2))) || (r_state == S_UPDATE);
    assign frame_ready   = (r_state == S_IDLE) && frame_valid;
    assign busy          = (r_state != S_IDLE);
    assign o_dbg_state   = r_state;

    always_comb begin
        dds_sdio = 4'b0000;
        if (r_state == S_INIT) begin
            dds_sdio[0] = r_shreg[SH_W-1];
        end else if (r_state == S_SHIFT) begin
            if (LANES == 4) begin
                dds_sdio = r_shreg[SH_W-1 -: 4];
            end else begin
                dds_sdio[0] = r_shreg[SH_W-1];
            end
        end
    end

    // Data advances on the clk where SCLK is high, so SDIO changes on the SCLK falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_DDSRST;
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_shreg <= '0;
            r_ch    <= '0;
            r_mask  <= '0;
            r_freq  <= '0;
            r_amp   <= '0;
        end else begin
            case (r_state)
                S_DDSRST: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_cnt   <= '0;
                        r_phase <= 1'b0;
                        r_shreg <= SH_W'(init_word) << (SH_W - INIT_W);
                        r_state <= S_INIT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_INIT: begin
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        r_shreg <= r_shreg << 1;
                        if (r_cnt == INIT_LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_INITUPD;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_INITUPD: begin
                    if (r_cnt == INITUPD_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_IDLE: begin
                    if (frame_valid) begin
                        r_mask <= ch_mask;
                        r_freq <= frame_freq;
                        r_amp  <= frame_amp;
                        if (w_first[CH_W]) begin
                            r_ch    <= w_first[CH_W-1:0];
                            r_shreg <= align_cmd(w_first_cmd);
                            r_cnt   <= '0;
                            r_phase <= 1'b0;
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        if (r_cnt == CMD_LAST) begin
                            r_cnt <= '0;
`ifdef DDS_UPDATE_PER_CH_EN
                            r_state <= S_UPDATE;
`else
                            if (w_next[CH_W]) begin
                                r_ch    <= w_next[CH_W-1:0];
                                r_shreg <= align_cmd(w_next_cmd);
                            end else begin
                                r_state <= S_UPDATE;
                            end
`endif
                        end else begin
                            r_shreg <= r_shreg << LANE_EFF;
                            r_cnt   <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_UPDATE: begin
                    if (r_cnt == UPD_LAST) begin
                        r_cnt <= '0;
`ifdef DDS_UPDATE_PER_CH_EN
                        if (w_next[CH_W]) begin
                            r_ch    <= w_next[CH_W-1:0];
                            r_shreg <= align_cmd(w_next_cmd);
                            r_phase <= 1'b0;
                            r_state <= S_SHIFT;
                        end else begin
                            r_state <= S_IDLE;
                        end
`else
                        r_state <= S_IDLE;
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_DDSRST;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_frame_streamer.sv
// Directed bench for dds_frame_streamer: power-up, init stream, frame streaming, handshake and mid-transfer reset.
module tb_dds_frame_streamer;

    localparam int NUM_CH     = 2;
    localparam int INIT_BYTES = 12;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [8*INIT_BYTES-1:0] init_word;
    logic [NUM_CH-1:0]       ch_mask;
    logic                    frame_valid;
    logic                    frame_ready;
    logic [32*NUM_CH-1:0]    frame_freq;
    logic [10*NUM_CH-1:0]    frame_amp;
    logic                    busy;
    logic                    dds_reset;
    logic                    dds_cs;
    logic                    dds_sclk;
    logic                    dds_io_update;
    logic [3:0]              dds_sdio;
    logic [2:0]              dbg_state;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    dds_frame_streamer #(
        .NUM_CH(NUM_CH), .LANES(4), .INIT_BYTES(INIT_BYTES),
        .CSR_CH_BASE(6), .RESET_HOLD(8), .GAP(4)
    ) dut (
        .clk(clk), .reset(rst), .init_word(init_word), .ch_mask(ch_mask),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_freq(frame_freq), .frame_amp(frame_amp), .busy(busy),
        .dds_reset(dds_reset), .dds_cs(dds_cs), .dds_sclk(dds_sclk),
        .dds_io_update(dds_io_update), .dds_sdio(dds_sdio), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_bytes(input string tag);
        check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Caller is at a negedge sample point. Collects bytes while CS is low, then counts
    // IO_UPDATE cycles and trailing CS-high busy cycles.
    task automatic run_burst(input int lanes, input string tag,
                             output int n_clk, output int n_upd, output int n_gap);
        int         t;
        int         nb;
        logic [7:0] cur;
        logic       lane_bad;
        logic       tmo;
        t = 0; nb = 0; cur = '0; lane_bad = 1'b0;
        n_clk = 0; n_upd = 0; n_gap = 0;
        while (dds_cs && t < 3000) begin
            @(negedge clk);
            t++;
        end
        tmo = (t >= 3000);
        check({tag, "_cs_fall_timeout"}, 64'(tmo), 64'(0));
        while (!dds_cs && n_clk < 3000) begin
            n_clk++;
            if (dds_sclk) begin
                if (lanes == 4) begin
                    cur = {cur[3:0], dds_sdio};
                    nb += 4;
                end else begin
                    cur = {cur[6:0], dds_sdio[0]};
                    nb += 1;
                end
                if (nb == 8) begin
                    got_q.push_back(cur);
                    nb = 0;
                end
            end
            if (lanes == 1 && dds_sdio[3:1] != 3'b000) lane_bad = 1'b1;
            @(negedge clk);
        end
        while (dds_io_update && n_upd < 100) begin
            n_upd++;
            @(negedge clk);
        end
        while (busy && dds_cs && !dds_io_update && n_gap < 100) begin
            n_gap++;
            @(negedge clk);
        end
        if (lanes == 1) check({tag, "_unused_lanes"}, 64'(lane_bad), 64'(0));
    endtask

    // Called just after a posedge with reset freshly released.
    task automatic powerup(input string tag);
        int c;
        int n_clk, n_upd, n_gap;
        c = 0;
        @(negedge clk);
        while (dds_reset && c < 2000) begin
            c++;
            @(negedge clk);
        end
        check({tag, "_reset_hold"}, 64'(c), 64'(8));
        for (int i = INIT_BYTES - 1; i >= 0; i--) exp_q.push_back(init_word[8*i +: 8]);
        run_burst(1, tag, n_clk, n_upd, n_gap);
        check_bytes({tag, "_init"});
        check({tag, "_init_clk"}, 64'(n_clk), 64'(192));
        check({tag, "_init_upd"}, 64'(n_upd), 64'(2));
        check({tag, "_init_gap"}, 64'(n_gap), 64'(4));
        check({tag, "_idle_busy"}, 64'(busy), 64'(0));
    endtask

    task automatic send_frame(input string tag, input logic [NUM_CH-1:0] m,
                              input logic [31:0] f0, input logic [9:0] a0,
                              input logic [31:0] f1, input logic [9:0] a1);
        frame_valid = 1'b1;
        ch_mask     = m;
        frame_freq  = {f1, f0};
        frame_amp   = {a1, a0};
        #1;
        check({tag, "_ready"}, 64'(frame_ready), 64'(1));
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        ch_mask     = NUM_CH'($urandom_range(0, 3));
        frame_freq  = {$urandom, $urandom};
        frame_amp   = 20'($urandom);
    endtask

    logic [7:0] f_both [22] = '{8'h00, 8'h46, 8'h04, 8'hAB, 8'hCD, 8'h12, 8'h34, 8'h06, 8'h00, 8'h13, 8'hFF,
                                8'h00, 8'h86, 8'h04, 8'hFE, 8'hFE, 8'h5A, 8'h5A, 8'h06, 8'h00, 8'h10, 8'hFF};
    logic [7:0] f_ch1 [11]  = '{8'h00, 8'h86, 8'h04, 8'h12, 8'h34, 8'h56, 8'h78, 8'h06, 8'h00, 8'h12, 8'hA5};

    initial begin
        int n_clk, n_upd, n_gap, rdy_cnt, rdy_busy, t;
        rst         = 1'b1;
        init_word   = 96'h0193_A5C3_0F1E_2D3C_4B5A_6978;
        ch_mask     = '0;
        frame_valid = 1'b0;
        frame_freq  = '0;
        frame_amp   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dds_reset", 64'(dds_reset), 64'(1));
        check("rst_cs", 64'(dds_cs), 64'(1));
        check("rst_sclk", 64'(dds_sclk), 64'(0));
        check("rst_io_update", 64'(dds_io_update), 64'(0));
        check("rst_sdio", 64'(dds_sdio), 64'(0));
        check("rst_ready", 64'(frame_ready), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        powerup("pu1");

        // Two-channel frame, 4 lanes.
        @(negedge clk);
        send_frame("f11", 2'b11, 32'hABCD1234, 10'd1023, 32'hFEFE5A5A, 10'd255);
        @(negedge clk);
`ifdef DDS_UPDATE_PER_CH_EN
        for (int i = 0; i < 11; i++) exp_q.push_back(f_both[i]);
        run_burst(4, "f11a", n_clk, n_upd, n_gap);
        check_bytes("f11a");
        check("f11a_clk", 64'(n_clk), 64'(44));
        check("f11a_upd", 64'(n_upd), 64'(2));
        for (int i = 11; i < 22; i++) exp_q.push_back(f_both[i]);
        run_burst(4, "f11b", n_clk, n_upd, n_gap);
        check_bytes("f11b");
        check("f11b_clk", 64'(n_clk), 64'(44));
        check("f11b_upd", 64'(n_upd), 64'(2));
`else
        for (int i = 0; i < 22; i++) exp_q.push_back(f_both[i]);
        run_burst(4, "f11", n_clk, n_upd, n_gap);
        check_bytes("f11");
        check("f11_clk", 64'(n_clk), 64'(88));
        check("f11_upd", 64'(n_upd), 64'(2));
`endif
        check("f11_gap", 64'(n_gap), 64'(0));
        check("f11_idle", 64'(busy), 64'(0));

        // Only channel 1 enabled; channel 0 data must not appear.
        send_frame("f10", 2'b10, 32'h0BADF00D, 10'h3C3, 32'h12345678, 10'h2A5);
        @(negedge clk);
        for (int i = 0; i < 11; i++) exp_q.push_back(f_ch1[i]);
        run_burst(4, "f10", n_clk, n_upd, n_gap);
        check_bytes("f10");
        check("f10_clk", 64'(n_clk), 64'(44));
        check("f10_upd", 64'(n_upd), 64'(2));

        // Empty mask: accepted but nothing shifted.
        send_frame("f00", 2'b00, 32'h11111111, 10'h111, 32'h22222222, 10'h222);
        @(negedge clk);
        check("f00_busy", 64'(busy), 64'(0));
        check("f00_cs", 64'(dds_cs), 64'(1));

        // frame_valid held high: one accept per 47-cycle frame, never while busy.
        ch_mask     = 2'b01;
        frame_freq  = {32'h0, 32'h0F0F0F0F};
        frame_amp   = {10'h0, 10'h100};
        frame_valid = 1'b1;
        rdy_cnt = 0; rdy_busy = 0;
        for (int i = 0; i < 141; i++) begin
            #1;
            if (frame_ready) rdy_cnt++;
            if (frame_ready && busy) rdy_busy++;
            @(negedge clk);
        end
        frame_valid = 1'b0;
        check("hold_ready_count", 64'(rdy_cnt), 64'(3));
        check("hold_ready_busy", 64'(rdy_busy), 64'(0));
        t = 0;
        while (busy && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("hold_idle", 64'(busy), 64'(0));

        // Reset in the middle of a shift.
        send_frame("mid", 2'b11, 32'hCAFEBABE, 10'h155, 32'h01020304, 10'h2AA);
        repeat (20) @(negedge clk);
        check("mid_in_shift_cs", 64'(dds_cs), 64'(0));
        #1 rst = 1'b1;
        #1;
        check("mid_cs", 64'(dds_cs), 64'(1));
        check("mid_sclk", 64'(dds_sclk), 64'(0));
        check("mid_dds_reset", 64'(dds_reset), 64'(1));
        check("mid_sdio", 64'(dds_sdio), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        init_word = 96'h5AC3_0011_2233_4455_6677_8899;
        powerup("pu2");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
